apb_capture_mailbox: RTL
========================

# apb_capture_mailbox

APB slave that sits directly downstream of the I2C-to-APB bridge and gives the external I2C host a buffered window into on-chip activity. Fabric logic pushes 8-bit samples into a small FIFO through a valid/ready port; the host drains it, checks status and controls capture through a 5-bit APB register map. It occupies the same APB port as the debugger and takes its place or sits beside it behind a PSEL decode.

## Interface
- DEPTH, 8, FIFO entries; legal values 2, 4, 8; count field is 4 bits.
- PCLK  in  1  single clock; all state updates on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  APB select.
- PADDR  in  5  APB register address.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data, valid in the completion cycle.
- PREADY  out  1  transfer completion / wait-state.
- PUSH_VALID  in  1  fabric sample valid.
- PUSH_DATA  in  8  fabric sample.
- PUSH_READY  out  1  sample accepted when high with PUSH_VALID.

## Operation
- Completion = PSEL & PENABLE & PREADY. Register side effects happen exactly once per transfer, at the completion edge.
- 0x00 DATA (R): returns FIFO head and pops. Empty: returns 0x00, no pop, sets UNDERFLOW. Writes ignored.
- 0x01 STATUS (R): [7] OVERFLOW sticky, [6] UNDERFLOW sticky, [5] full, [4] empty, [3:0] count. Writes ignored.
- 0x02 CTRL (R/W): [0] CAPTURE_EN (read back). [1] FLUSH, write-1 action, reads 0. [2] CLR_FLAGS, write-1 clears both sticky flags, reads 0. [7:3] read 0.
- 0x03 PEEK (R): head without pop; 0x00 when empty; no flag change.
- Other addresses: read 0x00, writes ignored, PREADY=1.
- Push: PUSH_READY = CAPTURE_EN & ~full (registered state only, independent of APB). Sample written at edge when PUSH_VALID & PUSH_READY.
- PUSH_VALID & CAPTURE_EN & full: sample dropped, OVERFLOW set. PUSH_VALID with CAPTURE_EN=0: ignored, no flag.
- Push and pop same edge: both take effect; count unchanged. Pop at full does not make that cycle's push acceptable (PUSH_READY already low; overflow set).
- Push while empty and DATA-read completes same edge: read returns 0x00, UNDERFLOW set, push stored.
- FLUSH: pointers and count to 0 at completion edge; a push in the same edge is discarded with no OVERFLOW. Sticky flags untouched.
- CLR_FLAGS and a new overflow/underflow in same edge: set wins.
- Pointers wrap modulo DEPTH; count 0..DEPTH.

## Timing
- Reset (PRESET high at edge): pointers, count, flags, CAPTURE_EN, wait-state flag to 0. Outputs after reset: PRDATA 0x00, PREADY 1, PUSH_READY 0. Storage contents need not be cleared.
- Reset during a transfer aborts it: no pop, no write effect.
- All accesses except DATA read: zero wait states; PREADY=1 in first access cycle.
- DATA read: one wait state. First access cycle PREADY=0 and wait flag sets; second cycle PREADY=1, PRDATA = head at that cycle, pop at that edge; wait flag clears.
- PRDATA is 0x00 whenever not in a read completion cycle.
- Push-to-visible latency: sample pushed at edge N appears in count/PEEK in cycle N+1.
- STATUS reflects registered state in the completion cycle (pre-edge values).

## Structure
- Package apb_capture_mailbox_pkg: address constants (ADDR_DATA, ADDR_STATUS, ADDR_CTRL, ADDR_PEEK), STATUS and CTRL bit positions.
- Sub-module sync_fifo (DEPTH, WIDTH=8): storage, read/write pointers, count, full/empty, push/pop/flush inputs, head output. Top holds APB decode, wait-state flag, CTRL and sticky flags.

## Test plan
- Reset then read STATUS -> 0x10 (empty), PREADY high first cycle; PUSH_READY 0.
- Write CTRL=0x01, push 0xA1,0xB2,0xC3 -> STATUS 0x03; PEEK 0xA1; DATA reads return 0xA1,0xB2,0xC3 each with exactly one PREADY-low cycle; STATUS 0x10.
- Push 9 samples 0x00..0x08 with DEPTH=8 -> ninth dropped, STATUS 0xA8; drain returns 0x00..0x07; write CTRL=0x05 -> STATUS 0x10.
- DATA read on empty FIFO -> PRDATA 0x00, STATUS 0x50; simultaneous push 0x5A on that completion edge -> next PEEK 0x5A, count 1.
- Full FIFO, DATA-read completion coincident with PUSH_VALID -> returns oldest, count stays 7 after, OVERFLOW set.
- Fill 3 entries, write CTRL=0x03 with concurrent push -> count 0, OVERFLOW clear; assert PRESET during DATA-read wait state -> no pop, PREADY 1 next cycle.

Source files
------------

// File: rtl/apb_capture_mailbox_pkg.sv
// Shared register map and bit positions for the APB capture mailbox.
package apb_capture_mailbox_pkg;

    localparam logic [4:0] ADDR_DATA   = 5'h00;
    localparam logic [4:0] ADDR_STATUS = 5'h01;
    localparam logic [4:0] ADDR_CTRL   = 5'h02;
    localparam logic [4:0] ADDR_PEEK   = 5'h03;

    localparam int ST_OVERFLOW  = 7;
    localparam int ST_UNDERFLOW = 6;
    localparam int ST_FULL      = 5;
    localparam int ST_EMPTY     = 4;

    localparam int CTRL_CAPTURE_EN = 0;
    localparam int CTRL_FLUSH      = 1;
    localparam int CTRL_CLR_FLAGS  = 2;

    function automatic logic [7:0] status_byte(input logic ovf, input logic udf,
                                               input logic full, input logic empty,
                                               input logic [3:0] count);
        return {ovf, udf, full, empty, count};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; caller guarantees no push when full and no pop when empty.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [3:0]       count,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // DEPTH is a power of two, so natural pointer rollover is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 4'(DEPTH));
    assign empty = (count == 4'd0);

endmodule

// File: rtl/apb_capture_mailbox.sv
// APB-visible capture FIFO: fabric pushes samples, the host drains/peeks and controls capture.
module apb_capture_mailbox
    import apb_capture_mailbox_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic [4:0] PADDR,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    input  logic       PUSH_VALID,
    input  logic [7:0] PUSH_DATA,
    output logic       PUSH_READY
);
    logic       wait_flag;
    logic       capture_en;
    logic       overflow;
    logic       underflow;
    logic [7:0] head;
    logic [3:0] count;
    logic       full;
    logic       empty;

    logic data_rd_access;
    logic done;
    logic rd_done;
    logic data_rd_done;
    logic ctrl_wr;
    logic flush;
    logic clr_flags;
    logic push;
    logic pop;
    logic ovf_set;
    logic udf_set;

    // DATA reads stall one cycle so the head is stable when the host samples it.
    assign data_rd_access = PSEL && PENABLE && !PWRITE && (PADDR == ADDR_DATA);
    assign PREADY         = !data_rd_access || wait_flag;

    assign done         = PSEL && PENABLE && PREADY;
    assign rd_done      = done && !PWRITE;
    assign data_rd_done = rd_done && (PADDR == ADDR_DATA);
    assign ctrl_wr      = done && PWRITE && (PADDR == ADDR_CTRL);
    assign flush        = ctrl_wr && PWDATA[CTRL_FLUSH];
    assign clr_flags    = ctrl_wr && PWDATA[CTRL_CLR_FLAGS];

    assign PUSH_READY = capture_en && !full;
    assign push       = PUSH_VALID && PUSH_READY && !flush;
    assign pop        = data_rd_done && !empty;
    // A flush discards the coincident sample without flagging it as lost.
    assign ovf_set    = PUSH_VALID && capture_en && full && !flush;
    assign udf_set    = data_rd_done && empty;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_flag  <= 1'b0;
            capture_en <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wait_flag <= data_rd_access && !wait_flag;
            if (ctrl_wr) capture_en <= PWDATA[CTRL_CAPTURE_EN];
            overflow  <= ovf_set || (overflow && !clr_flags);
            underflow <= udf_set || (underflow && !clr_flags);
        end
    end

    always_comb begin
        PRDATA = 8'h00;
        if (rd_done) begin
            case (PADDR)
                ADDR_DATA, ADDR_PEEK: PRDATA = empty ? 8'h00 : head;
                ADDR_STATUS:          PRDATA = status_byte(overflow, underflow, full, empty, count);
                ADDR_CTRL:            PRDATA = {7'b0, capture_en};
                default:              PRDATA = 8'h00;
            endcase
        end
    end

    logic unused_wdata;
    assign unused_wdata = &{1'b0, PWDATA[7:3]};

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (PUSH_DATA),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule
